// File: rtl/seg_time_display.sv
// rtl/seg_time_display.sv - MM.SS 4-digit 7-segment driver with BCD conversion and blink
// Optional LEADING_ZERO_BLANK_EN blanks a zero minutes-tens digit.
module seg_time_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] minutes,
    input  logic [7:0] seconds,
    input  logic       blink_tick,
    input  logic [1:0] blink_sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);
    localparam logic [3:0] DASH = 4'hA;

    typedef enum logic [1:0] {IDLE, LOAD, SUB, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [7:0]       rem_min_q, rem_min_d, rem_sec_q, rem_sec_d;
    logic [3:0]       ten_min_q, ten_min_d, ten_sec_q, ten_sec_d;
    logic             oor_min_q, oor_min_d, oor_sec_q, oor_sec_d;
    logic [7:0]       last_min_q, last_min_d, last_sec_q, last_sec_d;
    logic             dirty_q, dirty_d;
    logic [3:0][3:0]  dig_q, dig_d;
    logic             busy_q;
    logic             min_run, sec_run;

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic             phase_q;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d, seg_dec;
    logic             dp_q, dp_d, blank;
    logic [3:0]       cur_dig;

    always_comb begin
        state_d    = state_q;
        rem_min_d  = rem_min_q;
        rem_sec_d  = rem_sec_q;
        ten_min_d  = ten_min_q;
        ten_sec_d  = ten_sec_q;
        oor_min_d  = oor_min_q;
        oor_sec_d  = oor_sec_q;
        last_min_d = last_min_q;
        last_sec_d = last_sec_q;
        dirty_d    = dirty_q;
        dig_d      = dig_q;
        min_run    = !oor_min_q && (rem_min_q >= 8'd10);
        sec_run    = !oor_sec_q && (rem_sec_q >= 8'd10);
        case (state_q)
            IDLE: begin
                if (dirty_q || ({minutes, seconds} != {last_min_q, last_sec_q}))
                    state_d = LOAD;
            end
            LOAD: begin
                rem_min_d = minutes;
                rem_sec_d = seconds;
                ten_min_d = 4'd0;
                ten_sec_d = 4'd0;
                oor_min_d = minutes > 8'd99;
                oor_sec_d = seconds > 8'd99;
                state_d   = SUB;
            end
            SUB: begin
                if (min_run) begin
                    rem_min_d = rem_min_q - 8'd10;
                    ten_min_d = ten_min_q + 4'd1;
                end
                if (sec_run) begin
                    rem_sec_d = rem_sec_q - 8'd10;
                    ten_sec_d = ten_sec_q + 4'd1;
                end
                if (!min_run && !sec_run)
                    state_d = COMMIT;
            end
            COMMIT: begin
                dig_d[0] = oor_sec_q ? DASH : rem_sec_q[3:0];
                dig_d[1] = oor_sec_q ? DASH : ten_sec_q;
                dig_d[2] = oor_min_q ? DASH : rem_min_q[3:0];
                dig_d[3] = oor_min_q ? DASH : ten_min_q;
                // Out-of-range fields kept their raw value with a zero tens count.
                last_min_d = rem_min_q + ({4'd0, ten_min_q} * 8'd10);
                last_sec_d = rem_sec_q + ({4'd0, ten_sec_q} * 8'd10);
                dirty_d    = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_dig = dig_q[idx_q];
        blank   = phase_q && (idx_q[1] ? blink_sel[1] : blink_sel[0]);
        case (cur_dig)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            DASH:    seg_dec = 7'b0111111;
            default: seg_dec = 7'h7F;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q == 2'd3 && cur_dig == 4'd0)
            seg_dec = 7'h7F;
`endif
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank ? 7'h7F : seg_dec;
        dp_d  = !(idx_q == 2'd2 && !blank);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_min_q  <= 8'd0;
            rem_sec_q  <= 8'd0;
            ten_min_q  <= 4'd0;
            ten_sec_q  <= 4'd0;
            oor_min_q  <= 1'b0;
            oor_sec_q  <= 1'b0;
            last_min_q <= 8'd0;
            last_sec_q <= 8'd0;
            dirty_q    <= 1'b1;
            dig_q      <= '0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            phase_q    <= 1'b0;
            an_q       <= 4'b1111;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            rem_min_q  <= rem_min_d;
            rem_sec_q  <= rem_sec_d;
            ten_min_q  <= ten_min_d;
            ten_sec_q  <= ten_sec_d;
            oor_min_q  <= oor_min_d;
            oor_sec_q  <= oor_sec_d;
            last_min_q <= last_min_d;
            last_sec_q <= last_sec_d;
            dirty_q    <= dirty_d;
            dig_q      <= dig_d;
            busy_q     <= (state_d != IDLE);
            if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                cnt_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (blink_tick)
                phase_q <= ~phase_q;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_seg_time_display.sv
// tb/tb_seg_time_display.sv - self-checking bench for seg_time_display against a timing-level reference model
module tb_seg_time_display;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] minutes, seconds;
    logic       blink_tick;
    logic [1:0] blink_sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_time_display #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .minutes(minutes), .seconds(seconds),
        .blink_tick(blink_tick), .blink_sel(blink_sel),
        .an(an), .seg(seg), .dp(dp), .busy(busy)
    );

    // Reference model: display time from edge counts, conversion as a latency countdown.
    int m_k, m_phase, m_rem, m_loadp, m_dirty;
    int m_last_min, m_last_sec, m_cap_min, m_cap_sec, m_disp_min, m_disp_sec;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_busy;

    function automatic int tens_of(input int v);
        return (v > 99) ? 0 : v / 10;
    endfunction

    function automatic int code_of(input int idx, input int mn, input int sc);
        case (idx)
            0: return (sc > 99) ? -1 : sc % 10;
            1: return (sc > 99) ? -1 : sc / 10;
            2: return (mn > 99) ? -1 : mn % 10;
            default: return (mn > 99) ? -1 : mn / 10;
        endcase
    endfunction

    function automatic logic [6:0] seg_of(input int code);
        case (code)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10; -1: return 7'b0111111;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic tick();
        int idx, code, tm;
        bit blank;
        @(posedge clk);
        if (rst) begin
            e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
            m_k = 0; m_phase = 0; m_rem = 0; m_loadp = 0; m_dirty = 1;
            m_last_min = 0; m_last_sec = 0; m_disp_min = 0; m_disp_sec = 0;
        end else begin
            idx   = (m_k / DIV) % 4;
            code  = code_of(idx, m_disp_min, m_disp_sec);
            blank = (m_phase != 0) && ((idx >= 2) ? blink_sel[1] : blink_sel[0]);
            e_an  = ~(4'b0001 << idx);
            e_seg = blank ? 7'h7F : seg_of(code);
`ifdef LEADING_ZERO_BLANK_EN
            if (!blank && idx == 3 && code == 0) e_seg = 7'h7F;
`endif
            e_dp  = !(idx == 2 && !blank);
            m_k++;
            if (blink_tick) m_phase = !m_phase;
            if (m_loadp != 0) begin
                m_cap_min = int'(minutes);
                m_cap_sec = int'(seconds);
                tm = (tens_of(m_cap_min) > tens_of(m_cap_sec)) ? tens_of(m_cap_min) : tens_of(m_cap_sec);
                m_loadp = 0;
                m_rem = tm + 2;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_disp_min = m_cap_min; m_disp_sec = m_cap_sec;
                    m_last_min = m_cap_min; m_last_sec = m_cap_sec;
                    m_dirty = 0;
                end
            end else if (m_dirty != 0 || int'(minutes) != m_last_min || int'(seconds) != m_last_sec) begin
                m_loadp = 1;
            end
        end
        e_busy = (m_loadp != 0) || (m_rem > 0);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (e_busy && n < 60) begin tick(); n++; end
    endtask

    task automatic test_reset();
        rst = 1'b1; minutes = 8'd0; seconds = 8'd0; blink_tick = 1'b0; blink_sel = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({an, seg, dp, busy} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset an=%b seg=%h dp=%b busy=%b want 1111 7f 1 0", an, seg, dp, busy);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({an, seg, dp, busy} !== {e_an, e_seg, e_dp, e_busy}) begin
                errors++;
                $display("FAIL scan an=%b seg=%h dp=%b busy=%b want %b %h %b %b", an, seg, dp, busy, e_an, e_seg, e_dp, e_busy);
            end
        end
    endtask

    task automatic test_convert();
        int busy_cnt;
        wait_idle();
        minutes = 8'd12; seconds = 8'd59;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            checks++;
            if ({an, seg, dp, busy} !== {e_an, e_seg, e_dp, e_busy}) begin
                errors++;
                $display("FAIL convert an=%b seg=%h dp=%b busy=%b want %b %h %b %b", an, seg, dp, busy, e_an, e_seg, e_dp, e_busy);
            end
        end
        checks++;
        if (busy_cnt != 8) begin
            errors++;
            $display("FAIL convert_busy_len got=%0d want=8", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        wait_idle();
        minutes = 8'd34; seconds = 8'd59;
        tick(); tick(); tick();
        seconds = 8'd58;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if ({an, seg, dp, busy} !== {e_an, e_seg, e_dp, e_busy}) begin
                errors++;
                $display("FAIL b2b an=%b seg=%h dp=%b busy=%b want %b %h %b %b", an, seg, dp, busy, e_an, e_seg, e_dp, e_busy);
            end
        end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (an === 4'b1110) found = 1;
        end
        checks++;
        if (!found || seg !== 7'h00) begin
            errors++;
            $display("FAIL b2b_final found=%0d seg=%h want 00", found, seg);
        end
    endtask

    task automatic test_out_of_range();
        bit found;
        wait_idle();
        minutes = 8'd150; seconds = 8'd7;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if ({an, seg, dp, busy} !== {e_an, e_seg, e_dp, e_busy}) begin
                errors++;
                $display("FAIL oor an=%b seg=%h dp=%b busy=%b want %b %h %b %b", an, seg, dp, busy, e_an, e_seg, e_dp, e_busy);
            end
        end
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (an === 4'b0111) found = 1;
        end
        checks++;
        if (!found || seg !== 7'b0111111) begin
            errors++;
            $display("FAIL oor_dash found=%0d seg=%h want 3f", found, seg);
        end
    endtask

    task automatic test_blink();
        bit found;
        wait_idle();
        minutes = 8'd42; seconds = 8'd36;
        wait_idle(); wait_idle();
        blink_sel = 2'b01;
        for (int pulse = 0; pulse < 2; pulse++) begin
            blink_tick = 1'b1;
            tick();
            blink_tick = 1'b0;
            for (int i = 0; i < 18; i++) begin
                tick();
                checks++;
                if ({an, seg, dp, busy} !== {e_an, e_seg, e_dp, e_busy}) begin
                    errors++;
                    $display("FAIL blink%0d an=%b seg=%h dp=%b want %b %h %b", pulse, an, seg, dp, e_an, e_seg, e_dp);
                end
            end
            found = 0;
            for (int i = 0; i < 20 && !found; i++) begin
                tick();
                if (an === 4'b1110) found = 1;
            end
            checks++;
            if (!found || seg !== ((pulse == 0) ? 7'h7F : 7'h02)) begin
                errors++;
                $display("FAIL blink_idx0_%0d found=%0d seg=%h", pulse, found, seg);
            end
        end
        blink_sel = 2'b00;
    endtask

    task automatic test_leading_zero();
        bit found;
        logic [6:0] want;
`ifdef LEADING_ZERO_BLANK_EN
        want = 7'h7F;
`else
        want = 7'h40;
`endif
        wait_idle();
        minutes = 8'd5; seconds = 8'd30;
        for (int i = 0; i < 16; i++) tick();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (an === 4'b0111) found = 1;
        end
        checks++;
        if (!found || seg !== want) begin
            errors++;
            $display("FAIL lead_zero found=%0d seg=%h want %h", found, seg, want);
        end
    endtask

    task automatic test_reset_mid();
        wait_idle();
        minutes = 8'd99; seconds = 8'd99;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if ({an, seg, dp, busy} !== {e_an, e_seg, e_dp, e_busy}) begin
                errors++;
                $display("FAIL reset_mid an=%b seg=%h dp=%b busy=%b want %b %h %b %b", an, seg, dp, busy, e_an, e_seg, e_dp, e_busy);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) minutes = 8'($urandom_range(0, 110));
            if ($urandom_range(0, 9) == 0)  seconds = 8'($urandom_range(0, 110));
            if ($urandom_range(0, 29) == 0) blink_sel = 2'($urandom_range(0, 3));
            blink_tick = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if ({an, seg, dp, busy} !== {e_an, e_seg, e_dp, e_busy}) begin
                errors++;
                $display("FAIL random@%0d an=%b seg=%h dp=%b busy=%b want %b %h %b %b", i, an, seg, dp, busy, e_an, e_seg, e_dp, e_busy);
            end
        end
        rst = 1'b0;
        blink_tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_convert();
        test_back_to_back();
        test_out_of_range();
        test_blink();
        test_leading_zero();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
